// File: rtl/oled_spi_rx.sv
// oled_spi_rx: receiving end of an SSD1306-style serial link (sclk/sdin/dc/res).
// The link is oversampled in the clk domain, framed into bytes and decoded.
// Command bytes update the display state. Data bytes become frame-buffer writes
// at the current page/column address, which then advances.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   sclk, sdin, dc, res serial link (sclk idles high, sdin MSB first, res low = reset)
//   fb_we               one-cycle frame-buffer write strobe
//   fb_addr             {page, col} of the write
//   fb_wdata            data byte; bit 0 is the top pixel row of the page
//   disp_on             set by 0xAF, cleared by 0xAE
//   disp_all_on         set by 0xA5, cleared by 0xA4
//   contrast            last 0x81 argument
//
// Optional feature macro: OLED_RX_SEGREMAP_EN
//   When defined, 0xA0/0xA1 clear/set column mirroring and 0xC0/0xC8 clear/set
//   page mirroring of fb_addr. When undefined, those opcodes are no-ops.
module oled_spi_rx #(
    parameter int NUM_COLS    = 128,
    parameter int NUM_PAGES   = 4,
    parameter int SYNC_STAGES = 2,
    localparam int COL_W      = $clog2(NUM_COLS),
    localparam int PAGE_W     = $clog2(NUM_PAGES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    sclk,
    input  logic                    sdin,
    input  logic                    dc,
    input  logic                    res,
    output logic                    fb_we,
    output logic [PAGE_W+COL_W-1:0] fb_addr,
    output logic [7:0]              fb_wdata,
    output logic                    disp_on,
    output logic                    disp_all_on,
    output logic [7:0]              contrast
);

    localparam logic [COL_W-1:0]  COL_MAX  = COL_W'(NUM_COLS - 1);
    localparam logic [PAGE_W-1:0] PAGE_MAX = PAGE_W'(NUM_PAGES - 1);

    typedef enum logic [1:0] {OPC, ARG1, ARG2} state_t;
    typedef enum logic [1:0] {MODE_H = 2'd0, MODE_V = 2'd1, MODE_P = 2'd2} mode_t;

    // ---------------- synchronizers ----------------
    logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, dc_sync, res_sync;
    logic                   sclk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // sclk idles high; resetting its chain high avoids a false edge
            sclk_sync <= '1;
            sdin_sync <= '0;
            dc_sync   <= '0;
            res_sync  <= '0;
            sclk_q    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], sdin};
            dc_sync   <= {dc_sync[SYNC_STAGES-2:0], dc};
            res_sync  <= {res_sync[SYNC_STAGES-2:0], res};
            sclk_q    <= sclk_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, sdin_s, dc_s, res_s, rise;
    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdin_s = sdin_sync[SYNC_STAGES-1];
    assign dc_s   = dc_sync[SYNC_STAGES-1];
    assign res_s  = res_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_q;

    // ---------------- byte framing ----------------
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       byte_vld, byte_dc;
    logic [7:0] byte_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            byte_vld  <= 1'b0;
            byte_dc   <= 1'b0;
            byte_data <= '0;
        end else if (!res_s) begin
            bit_cnt  <= '0;
            byte_vld <= 1'b0;
        end else begin
            byte_vld <= 1'b0;
            if (rise) begin
                shreg   <= {shreg[5:0], sdin_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_vld  <= 1'b1;
                    byte_data <= {shreg, sdin_s};
                    byte_dc   <= dc_s;
                end
            end
        end
    end

    logic is_cmd, is_data;
    assign is_cmd  = byte_vld & ~byte_dc;
    assign is_data = byte_vld & byte_dc;

    // ---------------- decoder FSM ----------------
    function automatic logic [1:0] arg_count(input logic [7:0] op);
        case (op)
            8'h21, 8'h22:                      arg_count = 2'd2;
            8'h81, 8'h20, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB:        arg_count = 2'd1;
            default:                           arg_count = 2'd0;
        endcase
    endfunction

    state_t state, state_nxt;
    logic [7:0] opc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OPC;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!res_s || is_data) begin
            // a data byte abandons any half-received argument list
            state_nxt = OPC;
        end else if (is_cmd) begin
            case (state)
                OPC:     state_nxt = (arg_count(byte_data) != 2'd0) ? ARG1 : OPC;
                ARG1:    state_nxt = (arg_count(opc) == 2'd2) ? ARG2 : OPC;
                default: state_nxt = OPC;
            endcase
        end
    end

    // ---------------- display / address state ----------------
    mode_t             mode;
    logic [COL_W-1:0]  col, col_start, col_end, arg1;
    logic [PAGE_W-1:0] page, page_start, page_end;
    logic [COL_W-1:0]  col_out;
    logic [PAGE_W-1:0] page_out;

`ifdef OLED_RX_SEGREMAP_EN
    logic col_mirror, page_mirror;
    // mirroring only affects the address presented, never the counters
    assign col_out  = col_mirror  ? (COL_MAX - col)   : col;
    assign page_out = page_mirror ? (PAGE_MAX - page) : page;
`else
    assign col_out  = col;
    assign page_out = page;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            disp_on     <= 1'b0;
            disp_all_on <= 1'b0;
            contrast    <= 8'h7F;
            mode        <= MODE_P;
            col         <= '0;
            page        <= '0;
            col_start   <= '0;
            col_end     <= COL_MAX;
            page_start  <= '0;
            page_end    <= PAGE_MAX;
            opc         <= '0;
            arg1        <= '0;
`ifdef OLED_RX_SEGREMAP_EN
            col_mirror  <= 1'b0;
            page_mirror <= 1'b0;
`endif
        end else if (!res_s) begin
            fb_we       <= 1'b0;
            fb_addr     <= '0;
            fb_wdata    <= '0;
            disp_on     <= 1'b0;
            disp_all_on <= 1'b0;
            contrast    <= 8'h7F;
            mode        <= MODE_P;
            col         <= '0;
            page        <= '0;
            col_start   <= '0;
            col_end     <= COL_MAX;
            page_start  <= '0;
            page_end    <= PAGE_MAX;
            opc         <= '0;
            arg1        <= '0;
`ifdef OLED_RX_SEGREMAP_EN
            col_mirror  <= 1'b0;
            page_mirror <= 1'b0;
`endif
        end else begin
            fb_we <= 1'b0;
            if (is_data) begin
                fb_we    <= 1'b1;
                fb_wdata <= byte_data;
                fb_addr  <= {page_out, col_out};
                case (mode)
                    MODE_H: begin
                        if (col == col_end) begin
                            col  <= col_start;
                            page <= (page == page_end) ? page_start : page + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                    MODE_V: begin
                        if (page == page_end) begin
                            page <= page_start;
                            col  <= (col == col_end) ? col_start : col + 1'b1;
                        end else begin
                            page <= page + 1'b1;
                        end
                    end
                    default: col <= col + 1'b1;   // page mode: natural wrap at the last column
                endcase
            end else if (is_cmd) begin
                case (state)
                    OPC: begin
                        opc <= byte_data;
                        case (byte_data)
                            8'hAE: disp_on     <= 1'b0;
                            8'hAF: disp_on     <= 1'b1;
                            8'hA4: disp_all_on <= 1'b0;
                            8'hA5: disp_all_on <= 1'b1;
`ifdef OLED_RX_SEGREMAP_EN
                            8'hA0: col_mirror  <= 1'b0;
                            8'hA1: col_mirror  <= 1'b1;
                            8'hC0: page_mirror <= 1'b0;
                            8'hC8: page_mirror <= 1'b1;
`endif
                            default: begin
                                if (byte_data[7:3] == 5'b10110)
                                    page <= byte_data[PAGE_W-1:0];
                                else if (byte_data[7:4] == 4'h0)
                                    col[3:0] <= byte_data[3:0];
                                else if (byte_data[7:4] == 4'h1)
                                    col[COL_W-1:4] <= byte_data[COL_W-5:0];
                            end
                        endcase
                    end
                    ARG1: begin
                        case (opc)
                            8'h21, 8'h22: arg1 <= byte_data[COL_W-1:0];
                            8'h81:        contrast <= byte_data;
                            8'h20:        mode <= (byte_data[1:0] == 2'd3) ? MODE_P
                                                                            : mode_t'(byte_data[1:0]);
                            default: ;
                        endcase
                    end
                    ARG2: begin
                        if (opc == 8'h21) begin
                            col_start <= arg1;
                            col_end   <= byte_data[COL_W-1:0];
                            col       <= arg1;
                        end else begin
                            page_start <= arg1[PAGE_W-1:0];
                            page_end   <= byte_data[PAGE_W-1:0];
                            page       <= arg1[PAGE_W-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_oled_spi_rx.sv
module tb_oled_spi_rx;

    logic       clk = 1'b0;
    logic       rst_n, sclk, sdin, dc, res;
    logic       fb_we;
    logic [8:0] fb_addr;
    logic [7:0] fb_wdata;
    logic       disp_on, disp_all_on;
    logic [7:0] contrast;

    always #5 clk = ~clk;

    oled_spi_rx dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdin(sdin), .dc(dc), .res(res),
        .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata),
        .disp_on(disp_on), .disp_all_on(disp_all_on), .contrast(contrast)
    );

`ifdef OLED_RX_SEGREMAP_EN
    localparam logic [8:0] REMAP_EXP = 9'h1FF;
`else
    localparam logic [8:0] REMAP_EXP = 9'h000;
`endif

    // write monitor: counts strobe-high cycles, remembers the last write
    int         wr_cnt = 0;
    logic [8:0] last_addr = '0;
    logic [7:0] last_data = '0;
    always @(negedge clk) begin
        if (fb_we) begin
            wr_cnt    <= wr_cnt + 1;
            last_addr <= fb_addr;
            last_data <= fb_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic d);
        @(negedge clk);
        sclk = 1'b0; sdin = b; dc = d;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] b, input logic d, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i], d);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic d);
        send_bits(b, d, 8);
        repeat (4) @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       d;
        logic [8:0] addr;
        logic       on;
        logic       all;
        logic [7:0] con;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] b, input logic d, input logic [8:0] a,
                       input logic on, input logic all, input logic [7:0] con);
        vec_t v;
        v.b = b; v.d = d; v.addr = a; v.on = on; v.all = all; v.con = con;
        tbl.push_back(v);
    endtask

    initial begin
        int w0, k;
        vec_t v;

        // command stream and data with hand-computed addresses
        add(8'hAF,0,0,1,0,8'h7F); add(8'h81,0,0,1,0,8'h7F); add(8'h40,0,0,1,0,8'h40);
        add(8'h20,0,0,1,0,8'h40); add(8'h00,0,0,1,0,8'h40);
        add(8'h21,0,0,1,0,8'h40); add(8'h7E,0,0,1,0,8'h40); add(8'h7F,0,0,1,0,8'h40);
        add(8'h22,0,0,1,0,8'h40); add(8'h01,0,0,1,0,8'h40); add(8'h02,0,0,1,0,8'h40);
        add(8'h11,1,9'h0FE,1,0,8'h40); add(8'h12,1,9'h0FF,1,0,8'h40);
        add(8'h13,1,9'h17E,1,0,8'h40); add(8'h14,1,9'h17F,1,0,8'h40);
        add(8'h15,1,9'h0FE,1,0,8'h40);
        // page mode
        add(8'h20,0,0,1,0,8'h40); add(8'h02,0,0,1,0,8'h40);
        add(8'hB3,0,0,1,0,8'h40); add(8'h0F,0,0,1,0,8'h40); add(8'h17,0,0,1,0,8'h40);
        add(8'hAA,1,9'h1FF,1,0,8'h40); add(8'hBB,1,9'h180,1,0,8'h40);
        // aborted argument, then all-on, then an unknown opcode
        add(8'h81,0,0,1,0,8'h40); add(8'h55,1,9'h181,1,0,8'h40);
        add(8'hA5,0,0,1,1,8'h40); add(8'hE3,0,0,1,1,8'h40);
        // vertical mode over cols 0..1, pages 2..3
        add(8'h20,0,0,1,1,8'h40); add(8'h01,0,0,1,1,8'h40);
        add(8'h21,0,0,1,1,8'h40); add(8'h00,0,0,1,1,8'h40); add(8'h01,0,0,1,1,8'h40);
        add(8'h22,0,0,1,1,8'h40); add(8'h02,0,0,1,1,8'h40); add(8'h03,0,0,1,1,8'h40);
        add(8'h60,1,9'h100,1,1,8'h40); add(8'h61,1,9'h180,1,1,8'h40);
        add(8'h62,1,9'h101,1,1,8'h40);
        add(8'hAE,0,0,0,1,8'h40); add(8'hA4,0,0,0,0,8'h40);
        // segment/page remap opcodes
        add(8'hA1,0,0,0,0,8'h40); add(8'hC8,0,0,0,0,8'h40); add(8'hB0,0,0,0,0,8'h40);
        add(8'h00,0,0,0,0,8'h40); add(8'h10,0,0,0,0,8'h40);
        add(8'h01,1,REMAP_EXP,0,0,8'h40);

        rst_n = 1'b0; sclk = 1'b1; sdin = 1'b0; dc = 1'b0; res = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_we", fb_we, 0);
        chk("rst_addr", fb_addr, 0);
        chk("rst_wdata", fb_wdata, 0);
        chk("rst_on", disp_on, 0);
        chk("rst_all", disp_all_on, 0);
        chk("rst_contrast", contrast, 8'h7F);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            v  = tbl[i];
            w0 = wr_cnt;
            send_byte(v.b, v.d);
            if (v.d) begin
                chk($sformatf("v%0d_we", i), wr_cnt - w0, 1);
                chk($sformatf("v%0d_addr", i), last_addr, v.addr);
                chk($sformatf("v%0d_wdata", i), last_data, v.b);
            end else begin
                chk($sformatf("v%0d_nowe", i), wr_cnt - w0, 0);
            end
            chk($sformatf("v%0d_on", i), disp_on, v.on);
            chk($sformatf("v%0d_all", i), disp_all_on, v.all);
            chk($sformatf("v%0d_contrast", i), contrast, v.con);
        end

        // latency from the 8th sclk rise at the pin to the write strobe
        w0 = wr_cnt;
        send_bits(8'h5A, 1'b1, 7);
        @(negedge clk);
        sclk = 1'b0; sdin = 1'b0; dc = 1'b1;
        repeat (4) @(negedge clk);
        sclk = 1'b1;
        k = 0;
        while (k < 20 && !fb_we) begin
            @(negedge clk);
            k++;
        end
        chk("lat_cycles", k, 4);
        repeat (4) @(negedge clk);
        chk("lat_we", wr_cnt - w0, 1);
        chk("lat_wdata", last_data, 8'h5A);

        // display reset in the middle of a byte
        send_byte(8'hAF, 1'b0);
        send_byte(8'h81, 1'b0);
        send_byte(8'h22, 1'b0);
        chk("pre_res_contrast", contrast, 8'h22);
        w0 = wr_cnt;
        send_bits(8'hFF, 1'b1, 5);
        res = 1'b0;
        repeat (10) @(negedge clk);
        res = 1'b1;
        repeat (6) @(negedge clk);
        chk("res_on", disp_on, 0);
        chk("res_contrast", contrast, 8'h7F);
        send_byte(8'hAF, 1'b0);
        chk("res_nowe", wr_cnt - w0, 0);
        chk("res_af_on", disp_on, 1);
        send_byte(8'h77, 1'b1);
        chk("res_data_we", wr_cnt - w0, 1);
        chk("res_data_addr", last_addr, 9'h000);

        // asynchronous reset away from any clock edge
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_on", disp_on, 0);
        chk("arst_contrast", contrast, 8'h7F);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
